// File: rtl/vregfile_wb_pkg.sv
// Shared bank geometry for the banked vector register file.
// Holds the default geometry, the byte-enable width rule and the
// round-robin pointer type. The regfile and the operand-read side
// import the same package so the three blocks stay in agreement.
package vregfile_wb_pkg;

  localparam int DEF_NUMBANKS = 1;
  localparam int DEF_WIDTH    = 32;
  localparam int DEF_NUMREGS  = 32;

  // Byte-enable width. One enable per byte of every bank. An element
  // narrower than a byte gets a single enable per bank.
  function automatic int bew_of(input int numbanks, input int width);
    return (width >= 8) ? (numbanks * width / 8) : numbanks;
  endfunction

  // Which source wins the next bank conflict.
  typedef enum logic {
    RR_SRC0 = 1'b0,
    RR_SRC1 = 1'b1
  } rr_e;

endpackage

// File: rtl/vregfile_wb_slot.sv
// One-entry holding register for a single writeback producer.
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   in_valid/in_ready   producer handshake. in_ready depends only on the
//                       slot state and the grant, never on in_valid.
//   in_*                incoming entry fields (reg, data, byteen, bankmask)
//   grant               the arbiter retires the held entry this cycle
//   entry_*             held entry and its valid flag
module vregfile_wb_slot #(
  parameter int RW = 4,
  parameter int DW = 32,
  parameter int BW = 4,
  parameter int MW = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [RW-1:0] in_reg,
  input  logic [DW-1:0] in_data,
  input  logic [BW-1:0] in_byteen,
  input  logic [MW-1:0] in_bankmask,
  input  logic          grant,
  output logic          entry_v,
  output logic [RW-1:0] entry_reg,
  output logic [DW-1:0] entry_data,
  output logic [BW-1:0] entry_byteen,
  output logic [MW-1:0] entry_bankmask
);

  // A slot being retired this cycle can take a new entry at the same edge,
  // which gives one result per cycle per source.
  assign in_ready = !entry_v || grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_v        <= 1'b0;
      entry_reg      <= '0;
      entry_data     <= '0;
      entry_byteen   <= '0;
      entry_bankmask <= '0;
    end else if (in_valid && in_ready) begin
      entry_v        <= 1'b1;
      entry_reg      <= in_reg;
      entry_data     <= in_data;
      entry_byteen   <= in_byteen;
      entry_bankmask <= in_bankmask;
    end else if (grant) begin
      entry_v <= 1'b0;
    end
  end

endmodule

// File: rtl/vregfile_wb_arbiter.sv
// Write-side front end of the banked vector register file.
// Accepts writeback results from src0 (vector ALU) and src1 (vector load
// unit), holds one result per source, arbitrates per bank and drives
// the regfile write port from a registered output stage.
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   s0_valid/s0_ready, s0_reg, s0_data, s0_byteen, s0_bankmask   src0
//   s1_valid/s1_ready, s1_reg, s1_data, s1_byteen, s1_bankmask   src1
//   c_reg, c_writedatain, c_byteen, c_we   regfile write port (registered)
//   busy                             a slot is valid or a write is issuing
module vregfile_wb_arbiter
  import vregfile_wb_pkg::*;
#(
  parameter int NUMBANKS           = DEF_NUMBANKS,
  parameter int LOG2NUMBANKS       = $clog2(NUMBANKS),
  parameter int WIDTH              = DEF_WIDTH,
  parameter int NUMREGS            = DEF_NUMREGS,
  parameter int LOG2NUMREGS        = $clog2(NUMREGS),
  parameter int LOG2NUMREGSPERBANK = LOG2NUMREGS - LOG2NUMBANKS,
  parameter int BEW                = bew_of(NUMBANKS, WIDTH)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   s0_valid,
  output logic                                   s0_ready,
  input  logic [NUMBANKS*LOG2NUMREGSPERBANK-1:0] s0_reg,
  input  logic [NUMBANKS*WIDTH-1:0]              s0_data,
  input  logic [BEW-1:0]                         s0_byteen,
  input  logic [NUMBANKS-1:0]                    s0_bankmask,
  input  logic                                   s1_valid,
  output logic                                   s1_ready,
  input  logic [NUMBANKS*LOG2NUMREGSPERBANK-1:0] s1_reg,
  input  logic [NUMBANKS*WIDTH-1:0]              s1_data,
  input  logic [BEW-1:0]                         s1_byteen,
  input  logic [NUMBANKS-1:0]                    s1_bankmask,
  output logic [NUMBANKS*LOG2NUMREGSPERBANK-1:0] c_reg,
  output logic [NUMBANKS*WIDTH-1:0]              c_writedatain,
  output logic [BEW-1:0]                         c_byteen,
  output logic [NUMBANKS-1:0]                    c_we,
  output logic                                   busy
);

  localparam int RB  = LOG2NUMREGSPERBANK;
  localparam int RWT = NUMBANKS * RB;
  localparam int DWT = NUMBANKS * WIDTH;
  localparam int BPB = BEW / NUMBANKS;

  logic                v0, v1;
  logic [RWT-1:0]      r0, r1;
  logic [DWT-1:0]      d0, d1;
  logic [BEW-1:0]      b0, b1;
  logic [NUMBANKS-1:0] m0, m1;
  logic                g0, g1;
  logic                conflict;
  rr_e                 rr_reg, rr_next;

  logic [NUMBANKS-1:0] own0, own1;
  logic [NUMBANKS-1:0] we_next;
  logic [RWT-1:0]      reg_next;
  logic [DWT-1:0]      data_next;
  logic [BEW-1:0]      byteen_next;

  vregfile_wb_slot #(.RW(RWT), .DW(DWT), .BW(BEW), .MW(NUMBANKS)) u_slot0 (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (s0_valid),
    .in_ready       (s0_ready),
    .in_reg         (s0_reg),
    .in_data        (s0_data),
    .in_byteen      (s0_byteen),
    .in_bankmask    (s0_bankmask),
    .grant          (g0),
    .entry_v        (v0),
    .entry_reg      (r0),
    .entry_data     (d0),
    .entry_byteen   (b0),
    .entry_bankmask (m0)
  );

  vregfile_wb_slot #(.RW(RWT), .DW(DWT), .BW(BEW), .MW(NUMBANKS)) u_slot1 (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (s1_valid),
    .in_ready       (s1_ready),
    .in_reg         (s1_reg),
    .in_data        (s1_data),
    .in_byteen      (s1_byteen),
    .in_bankmask    (s1_bankmask),
    .grant          (g1),
    .entry_v        (v1),
    .entry_reg      (r1),
    .entry_data     (d1),
    .entry_byteen   (b1),
    .entry_bankmask (m1)
  );

  // Grants are decided on the held entries only. Disjoint masks retire
  // together; overlapping masks retire one per cycle, alternating.
  always_comb begin
    conflict = v0 && v1 && (|(m0 & m1));
    g0       = v0;
    g1       = v1;
    rr_next  = rr_reg;
    if (conflict) begin
      g0      = (rr_reg == RR_SRC0);
      g1      = (rr_reg == RR_SRC1);
      rr_next = (rr_reg == RR_SRC0) ? RR_SRC1 : RR_SRC0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_reg <= RR_SRC0;
    end else begin
      rr_reg <= rr_next;
    end
  end

  // Per-bank owner select. At most one source owns a bank because granted
  // pairs never overlap. Banks without a write keep their previous fields.
  genvar gi;
  generate
    for (gi = 0; gi < NUMBANKS; gi++) begin : g_bank
      assign own0[gi] = g0 && m0[gi];
      assign own1[gi] = g1 && m1[gi];
      assign we_next[gi] = own0[gi] || own1[gi];
      assign reg_next[gi*RB +: RB] =
        own0[gi] ? r0[gi*RB +: RB] : own1[gi] ? r1[gi*RB +: RB] : c_reg[gi*RB +: RB];
      assign data_next[gi*WIDTH +: WIDTH] =
        own0[gi] ? d0[gi*WIDTH +: WIDTH] :
        own1[gi] ? d1[gi*WIDTH +: WIDTH] : c_writedatain[gi*WIDTH +: WIDTH];
      assign byteen_next[gi*BPB +: BPB] =
        own0[gi] ? b0[gi*BPB +: BPB] : own1[gi] ? b1[gi*BPB +: BPB] : c_byteen[gi*BPB +: BPB];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_we          <= '0;
      c_reg         <= '0;
      c_writedatain <= '0;
      c_byteen      <= '0;
    end else begin
      c_we          <= we_next;
      c_reg         <= reg_next;
      c_writedatain <= data_next;
      c_byteen      <= byteen_next;
    end
  end

  assign busy = v0 || v1 || (|c_we);

endmodule

// File: tb/tb_vregfile_wb_arbiter.sv
module tb_vregfile_wb_arbiter;

  localparam int NB  = 2;
  localparam int W   = 32;
  localparam int RW  = 4;
  localparam int BEW = 8;
  localparam int BPB = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic              drv_valid [2];
  logic [NB*RW-1:0]  drv_reg   [2];
  logic [NB*W-1:0]   drv_data  [2];
  logic [BEW-1:0]    drv_be    [2];
  logic [NB-1:0]     drv_mask  [2];

  logic              s0_valid, s1_valid, s0_ready, s1_ready, busy;
  logic [NB*RW-1:0]  s0_reg, s1_reg, c_reg;
  logic [NB*W-1:0]   s0_data, s1_data, c_writedatain;
  logic [BEW-1:0]    s0_byteen, s1_byteen, c_byteen;
  logic [NB-1:0]     s0_bankmask, s1_bankmask, c_we;

  assign s0_valid = drv_valid[0];
  assign s0_reg = drv_reg[0];
  assign s0_data = drv_data[0];
  assign s0_byteen = drv_be[0];
  assign s0_bankmask = drv_mask[0];
  assign s1_valid = drv_valid[1];
  assign s1_reg = drv_reg[1];
  assign s1_data = drv_data[1];
  assign s1_byteen = drv_be[1];
  assign s1_bankmask = drv_mask[1];

  vregfile_wb_arbiter #(
    .NUMBANKS(2), .LOG2NUMBANKS(1), .WIDTH(32), .NUMREGS(32),
    .LOG2NUMREGS(5), .LOG2NUMREGSPERBANK(4)
  ) dut (
    .clk(clk), .reset(reset),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_reg(s0_reg), .s0_data(s0_data),
    .s0_byteen(s0_byteen), .s0_bankmask(s0_bankmask),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_reg(s1_reg), .s1_data(s1_data),
    .s1_byteen(s1_byteen), .s1_bankmask(s1_bankmask),
    .c_reg(c_reg), .c_writedatain(c_writedatain), .c_byteen(c_byteen),
    .c_we(c_we), .busy(busy)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each source holds at most one pending result. Pending results whose
  // banks overlap take turns; otherwise every pending result retires.
  logic              mv    [2];
  logic [NB*RW-1:0]  mreg  [2];
  logic [NB*W-1:0]   mdata [2];
  logic [BEW-1:0]    mbe   [2];
  logic [NB-1:0]     mmask [2];
  logic              mrr;
  logic [1:0]        mg;
  logic              mconf;
  logic [NB-1:0]     e_we;
  logic [NB*RW-1:0]  e_reg;
  logic [NB*W-1:0]   e_data;
  logic [BEW-1:0]    e_be;
  logic              cmp_en = 1'b0;

  always_comb begin
    mconf = mv[0] && mv[1] && ((mmask[0] & mmask[1]) != 0);
    mg = {mv[1], mv[0]};
    if (mconf) mg = mrr ? 2'b10 : 2'b01;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mv[0] <= 1'b0;
      mv[1] <= 1'b0;
      mrr <= 1'b0;
      e_we <= '0;
      e_reg <= '0;
      e_data <= '0;
      e_be <= '0;
    end else begin
      e_we <= (mg[0] ? mmask[0] : 2'b00) | (mg[1] ? mmask[1] : 2'b00);
      for (int k = 0; k < NB; k++) begin
        for (int s = 0; s < 2; s++) begin
          if (mg[s] && mmask[s][k] && !(s == 1 && mg[0] && mmask[0][k])) begin
            e_reg[k*RW +: RW] <= mreg[s][k*RW +: RW];
            e_data[k*W +: W] <= mdata[s][k*W +: W];
            e_be[k*BPB +: BPB] <= mbe[s][k*BPB +: BPB];
          end
        end
      end
      if (mconf) mrr <= !mrr;
      for (int s = 0; s < 2; s++) begin
        if (drv_valid[s] && (!mv[s] || mg[s])) begin
          mv[s] <= 1'b1;
          mreg[s] <= drv_reg[s];
          mdata[s] <= drv_data[s];
          mbe[s] <= drv_be[s];
          mmask[s] <= drv_mask[s];
        end else if (mg[s]) begin
          mv[s] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_s0_ready", 64'(s0_ready), 64'(!mv[0] || mg[0]));
      chk("m_s1_ready", 64'(s1_ready), 64'(!mv[1] || mg[1]));
      chk("m_c_we", 64'(c_we), 64'(e_we));
      chk("m_c_reg", 64'(c_reg), 64'(e_reg));
      chk("m_c_data", c_writedatain, e_data);
      chk("m_c_byteen", 64'(c_byteen), 64'(e_be));
      chk("m_busy", 64'(busy), 64'(mv[0] || mv[1] || (e_we != 0)));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    for (int s = 0; s < 2; s++) begin
      drv_valid[s] = 1'b0;
      drv_reg[s] = '0;
      drv_data[s] = '0;
      drv_be[s] = '0;
      drv_mask[s] = '0;
    end
  endtask

  task automatic nc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic put(input int s, input logic [1:0] mask, input logic [7:0] r,
                     input logic [63:0] d, input logic [7:0] be);
    drv_valid[s] = 1'b1;
    drv_mask[s] = mask;
    drv_reg[s] = r;
    drv_data[s] = d;
    drv_be[s] = be;
  endtask

  initial begin
    idle();
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cmp_en = 1'b1;
    chk("rst_c_we", 64'(c_we), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);

    // single write, two-cycle latency, one-cycle pulse
    nc();
    put(0, 2'b01, 8'h05, 64'hDEADBEEF, 8'h0F);
    mid();
    chk("t2_s0_ready", 64'(s0_ready), 64'h1);
    nc(); idle();
    nc(); mid();
    chk("t2_c_we", 64'(c_we), 64'h1);
    chk("t2_c_reg", 64'(c_reg[3:0]), 64'h5);
    chk("t2_c_data", 64'(c_writedatain[31:0]), 64'hDEADBEEF);
    chk("t2_c_byteen", 64'(c_byteen[3:0]), 64'hF);
    nc(); mid();
    chk("t2_c_we_off", 64'(c_we), 64'h0);

    // disjoint banks retire together
    nc();
    put(0, 2'b01, 8'h03, 64'h1111, 8'hFF);
    put(1, 2'b10, 8'h70, 64'h2222_0000_0000, 8'hFF);
    mid();
    chk("t3_ready", 64'({s1_ready, s0_ready}), 64'h3);
    nc(); idle(); mid();
    chk("t3_ready_c1", 64'({s1_ready, s0_ready}), 64'h3);
    nc(); mid();
    chk("t3_c_we", 64'(c_we), 64'h3);
    chk("t3_c_reg", 64'(c_reg), 64'h73);
    nc(); nc();

    // conflict: src0 first, then src1 wins the next conflict
    put(0, 2'b01, 8'h01, 64'hA0, 8'h0F);
    put(1, 2'b01, 8'h02, 64'hB0, 8'h0F);
    nc(); idle(); mid();
    chk("t4_s1_blocked", 64'(s1_ready), 64'h0);
    chk("t4_s0_ready", 64'(s0_ready), 64'h1);
    nc(); mid();
    chk("t4_first_we", 64'(c_we), 64'h1);
    chk("t4_first_reg", 64'(c_reg[3:0]), 64'h1);
    nc(); mid();
    chk("t4_second_we", 64'(c_we), 64'h1);
    chk("t4_second_reg", 64'(c_reg[3:0]), 64'h2);
    nc();
    put(0, 2'b01, 8'h03, 64'hA1, 8'h0F);
    put(1, 2'b01, 8'h04, 64'hB1, 8'h0F);
    nc(); idle(); mid();
    chk("t4b_s0_blocked", 64'(s0_ready), 64'h0);
    nc(); mid();
    chk("t4b_first_reg", 64'(c_reg[3:0]), 64'h4);
    nc(); mid();
    chk("t4b_second_reg", 64'(c_reg[3:0]), 64'h3);
    nc(); nc();

    // back-to-back stream from src0
    for (int t = 0; t < 6; t++) begin
      if (t < 4) put(0, 2'b01, 8'(t + 1), 64'(t), 8'h0F);
      else idle();
      mid();
      if (t < 4) chk("t5_s0_ready", 64'(s0_ready), 64'h1);
      if (t >= 2) begin
        chk("t5_c_we", 64'(c_we), 64'h1);
        chk("t5_c_reg", 64'(c_reg[3:0]), 64'(t - 1));
      end
      nc();
    end
    mid();
    chk("t5_c_we_off", 64'(c_we), 64'h0);

    // asynchronous reset while writes are in flight
    nc();
    for (int t = 0; t < 3; t++) begin
      put(0, 2'b01, 8'h09, 64'h99, 8'h0F);
      put(1, 2'b10, 8'h80, 64'h88_0000_0000, 8'hF0);
      nc();
    end
    idle();
    #2 reset = 1'b1;
    #1;
    chk("t1_c_we", 64'(c_we), 64'h0);
    chk("t1_busy", 64'(busy), 64'h0);
    chk("t1_ready", 64'({s1_ready, s0_ready}), 64'h3);
    nc(); reset = 1'b0;
    nc(); mid();
    chk("t1_after_c_we", 64'(c_we), 64'h0);

    // blocked src1 entry dropped by reset; rr back to src0
    nc();
    put(0, 2'b01, 8'h0A, 64'hAA, 8'h0F);
    put(1, 2'b01, 8'h0B, 64'hBB, 8'h0F);
    nc(); idle(); mid();
    chk("t6_s1_held", 64'(s1_ready), 64'h0);
    nc(); mid();
    #1 reset = 1'b1;
    #1;
    chk("t6_rst_ready", 64'(s1_ready), 64'h1);
    chk("t6_rst_busy", 64'(busy), 64'h0);
    nc(); reset = 1'b0;
    for (int t = 0; t < 3; t++) begin
      mid();
      chk("t6_no_stale", 64'(c_we), 64'h0);
      chk("t6_s1_ready", 64'(s1_ready), 64'h1);
      nc();
    end
    put(0, 2'b01, 8'h0C, 64'hCC, 8'h0F);
    put(1, 2'b01, 8'h0D, 64'hDD, 8'h0F);
    nc(); idle();
    nc(); mid();
    chk("t6_rr0_reg", 64'(c_reg[3:0]), 64'hC);
    nc(); nc();

    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      for (int s = 0; s < 2; s++) begin
        drv_valid[s] = ($urandom_range(0, 99) < 60);
        drv_mask[s] = 2'($urandom_range(0, 3));
        drv_reg[s] = 8'($urandom);
        drv_data[s] = {$urandom, $urandom};
        drv_be[s] = 8'($urandom);
      end
      if (c == 200) begin
        #2 reset = 1'b1;
      end else if (c == 201) begin
        reset = 1'b0;
      end
      nc();
    end
    idle();
    repeat (4) nc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
